// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// npu_sram_pkg
// Shared definitions for the two-requester SRAM port arbiter:
//   - default widths of the shared SRAM port (word address, data, byteenable)
//   - owner_t : which requester currently holds the port
// -----------------------------------------------------------------------------
package npu_sram_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_if
// One requester's command/response bundle toward the SRAM port arbiter.
//   valid         master -> slave  command present
//   ready         slave  -> master command accepted this cycle
//   address       master -> slave  word address
//   write         master -> slave  1 = write, 0 = read
//   byteenable    master -> slave  byte lanes for writes
//   writedata     master -> slave  write data
//   readdata      slave  -> master read data, qualified by readdatavalid
//   readdatavalid slave  -> master read data valid (one cycle, latency 1)
//
// Handshake: a command transfers on a rising clk edge where valid && ready.
// ready depends combinationally on valid of both requesters, so the master
// must not derive valid from ready. The master may withdraw or change a
// command that has not transferred; every accepted read returns exactly one
// readdatavalid pulse on the following cycle, writes return nothing.
// -----------------------------------------------------------------------------
interface sram_port_arbiter_if #(
    parameter int ADDR_W = npu_sram_pkg::ADDR_W_DEF,
    parameter int DATA_W = npu_sram_pkg::DATA_W_DEF,
    parameter int BE_W   = npu_sram_pkg::BE_W_DEF
);

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output valid, address, write, byteenable, writedata,
        input  ready, readdata, readdatavalid
    );

    modport slave (
        input  valid, address, write, byteenable, writedata,
        output ready, readdata, readdatavalid
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one port of a dual-port SRAM between two requesters (m0, m1).
// The winner is chosen combinationally every cycle, so a command can be
// accepted every cycle with no bubble on an owner switch. Under contention
// the current owner keeps the port until it has taken MAX_HOLD consecutive
// grants, then the other requester wins. Reads return with a fixed latency
// of one cycle (the SRAM output is unregistered and valid the cycle after
// the address edge).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   m0, m1               requester bundles (slave side)
//   sram_address/byteenable/write/writedata/chipselect/clken  SRAM command
//   sram_readdata        SRAM read data
//   dbg_owner_o          current owner register
//   dbg_hold_cnt_o       consecutive-grant counter of the owner
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import npu_sram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BE_W     = BE_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                reset,

    sram_port_arbiter_if.slave  m0,
    sram_port_arbiter_if.slave  m1,

    output logic [ADDR_W-1:0]   sram_address,
    output logic [BE_W-1:0]     sram_byteenable,
    output logic                sram_write,
    output logic [DATA_W-1:0]   sram_writedata,
    output logic                sram_chipselect,
    output logic                sram_clken,
    input  logic [DATA_W-1:0]   sram_readdata,

    output owner_t              dbg_owner_o,
    output logic [7:0]          dbg_hold_cnt_o
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    owner_t     owner_q, owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       rd_pend0_q, rd_pend0_d;
    logic       rd_pend1_q, rd_pend1_d;

    logic       grant0;
    logic       grant1;
    owner_t     winner;

    // State register. Reset also drops any read return that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN0;
            hold_cnt_q <= 8'd0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
        end
    end

    // Arbitration and next state.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        winner     = owner_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;

        // Nothing is granted while reset is held, even though the
        // registers are already at their reset values.
        if (!reset) begin
            if (m0.valid && m1.valid) begin
                if (hold_cnt_q == HOLD_MAX) begin
                    // Owner has used up its share; hand the port over.
                    grant0 = (owner_q == OWN1);
                    grant1 = (owner_q == OWN0);
                end else begin
                    grant0 = (owner_q == OWN0);
                    grant1 = (owner_q == OWN1);
                end
            end else begin
                grant0 = m0.valid;
                grant1 = m1.valid;
            end
        end

        if (grant0 || grant1) begin
            winner = grant1 ? OWN1 : OWN0;
            if (winner != owner_q) begin
                owner_d    = winner;
                hold_cnt_d = 8'd1;
            end else if (hold_cnt_q < HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end

        rd_pend0_d = grant0 && !m0.write;
        rd_pend1_d = grant1 && !m1.write;
    end

    // SRAM command mux; with no grant the m0 fields pass through but
    // chipselect and write stay low.
    assign sram_address    = grant1 ? m1.address    : m0.address;
    assign sram_byteenable = grant1 ? m1.byteenable : m0.byteenable;
    assign sram_writedata  = grant1 ? m1.writedata  : m0.writedata;
    assign sram_write      = (grant0 && m0.write) || (grant1 && m1.write);
    assign sram_chipselect = grant0 || grant1;
    assign sram_clken      = 1'b1;

    assign m0.ready         = grant0;
    assign m1.ready         = grant1;
    assign m0.readdata      = sram_readdata;
    assign m1.readdata      = sram_readdata;
    assign m0.readdatavalid = rd_pend0_q;
    assign m1.readdatavalid = rd_pend1_q;

    assign dbg_owner_o    = owner_q;
    assign dbg_hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Drives two requesters into sram_port_arbiter (MAX_HOLD = 8) backed by a
// behavioural SRAM, plus a second instance with MAX_HOLD = 1 for the
// alternation case. A reference model predicts grants, arbiter state and
// read data; read returns are checked from an expected queue.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;
    import npu_sram_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int BE_W     = 2;
    localparam int MAX_HOLD = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (MAX_HOLD = 8) ----------------
    sram_port_arbiter_if m0_if ();
    sram_port_arbiter_if m1_if ();

    logic [ADDR_W-1:0] sram_address;
    logic [BE_W-1:0]   sram_byteenable;
    logic              sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic              sram_chipselect;
    logic              sram_clken;
    logic [DATA_W-1:0] sram_readdata;
    owner_t            dbg_owner;
    logic [7:0]        dbg_hold_cnt;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .sram_address   (sram_address),
        .sram_byteenable(sram_byteenable),
        .sram_write     (sram_write),
        .sram_writedata (sram_writedata),
        .sram_chipselect(sram_chipselect),
        .sram_clken     (sram_clken),
        .sram_readdata  (sram_readdata),
        .dbg_owner_o    (dbg_owner),
        .dbg_hold_cnt_o (dbg_hold_cnt)
    );

    // ---------------- DUT (MAX_HOLD = 1) ----------------
    sram_port_arbiter_if a0_if ();
    sram_port_arbiter_if a1_if ();

    logic [ADDR_W-1:0] alt_address;
    logic [BE_W-1:0]   alt_byteenable;
    logic              alt_write;
    logic [DATA_W-1:0] alt_writedata;
    logic              alt_chipselect;
    logic              alt_clken;
    owner_t            alt_owner;
    logic [7:0]        alt_hold_cnt;
    logic [DATA_W-1:0] alt_readdata = '0;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(1)
    ) dut_alt (
        .clk            (clk),
        .reset          (reset),
        .m0             (a0_if),
        .m1             (a1_if),
        .sram_address   (alt_address),
        .sram_byteenable(alt_byteenable),
        .sram_write     (alt_write),
        .sram_writedata (alt_writedata),
        .sram_chipselect(alt_chipselect),
        .sram_clken     (alt_clken),
        .sram_readdata  (alt_readdata),
        .dbg_owner_o    (alt_owner),
        .dbg_hold_cnt_o (alt_hold_cnt)
    );

    // ---------------- behavioural SRAM (driven by DUT outputs) ----------------
    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];
    logic [DATA_W-1:0] sram_rd_q = '0;
    assign sram_readdata = sram_rd_q;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_chipselect) begin
            if (sram_write)
                sram_mem[sram_address] <= merge(sram_mem[sram_address], sram_writedata, sram_byteenable);
            else
                sram_rd_q <= sram_mem[sram_address];
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int passes = 0;
    logic [DATA_W:0] exp_q[$];   // {requester id, read data}

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Whoever holds the port keeps it under contention until it has had
    // MAX_HOLD grants in a row; a lone requester always wins.
    int ref_owner  = 0;
    int ref_streak = 0;

    always @(negedge clk) begin
        int win;
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] d;
        if (reset) begin
            ref_owner  = 0;
            ref_streak = 0;
            win = -1;
        end else if (m0_if.valid && m1_if.valid) begin
            win = (ref_streak == MAX_HOLD) ? 1 - ref_owner : ref_owner;
        end else if (m0_if.valid) begin
            win = 0;
        end else if (m1_if.valid) begin
            win = 1;
        end else begin
            win = -1;
        end

        a  = (win == 1) ? m1_if.address    : m0_if.address;
        w  = (win == 1) ? m1_if.write      : m0_if.write;
        be = (win == 1) ? m1_if.byteenable : m0_if.byteenable;
        d  = (win == 1) ? m1_if.writedata  : m0_if.writedata;

        check("m0_ready",     32'(m0_if.ready),     32'(win == 0));
        check("m1_ready",     32'(m1_if.ready),     32'(win == 1));
        check("chipselect",   32'(sram_chipselect), 32'(win >= 0));
        check("sram_write",   32'(sram_write),      32'((win >= 0) && w));
        check("clken",        32'(sram_clken),      32'd1);
        check("owner",        32'(dbg_owner),       32'(ref_owner));
        check("hold_cnt",     32'(dbg_hold_cnt),    32'(ref_streak));
        if (win >= 0) begin
            check("sram_address", 32'(sram_address), 32'(a));
            if (w) begin
                check("sram_wdata", 32'(sram_writedata),  32'(d));
                check("sram_be",    32'(sram_byteenable), 32'(be));
            end
        end

        if (win >= 0) begin
            if (win == ref_owner) begin
                if (ref_streak < MAX_HOLD) ref_streak++;
            end else begin
                ref_owner  = win;
                ref_streak = 1;
            end
            if (w) ref_mem[a] = merge(ref_mem[a], d, be);
            else   exp_q.push_back({1'(win), ref_mem[a]});
        end
    end

    // ---------------- read-return monitor ----------------
    always @(posedge clk) begin
        logic [DATA_W:0] e;
        #2;
        if (m0_if.readdatavalid && m1_if.readdatavalid) begin
            checks++;
            $display("FAIL rdv_both got=11 exp=one-hot t=%0t", $time);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (m0_if.readdatavalid || m1_if.readdatavalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL rdv_unexpected got=m%0d exp=none t=%0t", m1_if.readdatavalid, $time);
            end else begin
                e = exp_q.pop_front();
                check("rdv_id",   32'(m1_if.readdatavalid), 32'(e[DATA_W]));
                check("readdata", 32'(m1_if.readdatavalid ? m1_if.readdata : m0_if.readdata),
                      32'(e[DATA_W-1:0]));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            $display("FAIL rdv_missing got=none exp=m%0d data=%0h t=%0t", e[DATA_W], e[DATA_W-1:0], $time);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int n, input bit v, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        if (n == 0) begin
            m0_if.valid = v; m0_if.write = w; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.valid = v; m1_if.write = w; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic idle();
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, DEPTH - 1));
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    // Called just after a clock edge. With busy set both requesters keep
    // presenting reads through reset and into the first free cycle.
    task automatic apply_reset(input bit busy);
        reset = 1'b1;
        exp_q.delete();
        if (busy) begin
            set_m(0, 1, 0, rand_addr(), 2'b11, '0);
            set_m(1, 1, 0, rand_addr(), 2'b11, '0);
        end else begin
            idle();
        end
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        idle();
        a0_if.valid = 0; a0_if.write = 0; a0_if.address = '0; a0_if.byteenable = '0; a0_if.writedata = '0;
        a1_if.valid = 0; a1_if.write = 0; a1_if.address = '0; a1_if.byteenable = '0; a1_if.writedata = '0;
        cyc();
        apply_reset(0);

        // Write-then-read across requesters.
        set_m(0, 1, 1, 12'h123, 2'b11, 16'hBEEF); cyc();
        idle(); set_m(1, 1, 0, 12'h123, 2'b11, '0); cyc();
        idle(); cyc(); cyc();

        // Byte-lane write at the top address, then wrap to address 0.
        set_m(0, 1, 1, 12'hFFF, 2'b11, 16'h5555); cyc();
        idle(); set_m(1, 1, 1, 12'hFFF, 2'b01, 16'h12AB); cyc();
        set_m(1, 1, 0, 12'hFFF, 2'b00, '0); cyc();
        idle(); set_m(0, 1, 0, 12'h000, 2'b00, '0); cyc();
        idle(); cyc(); cyc();

        // Owner m0 drops out after three grants while m1 waits.
        apply_reset(0);
        set_m(0, 1, 0, 12'h010, 2'b11, '0);
        set_m(1, 1, 0, 12'h011, 2'b11, '0);
        repeat (3) cyc();
        set_m(0, 0, 0, '0, '0, '0);
        cyc();
        idle(); cyc(); cyc();

        // Continuous contention: 8 grants each, no gaps.
        apply_reset(0);
        for (int k = 0; k < 40; k++) begin
            set_m(0, 1, 0, rand_addr(), 2'b11, '0);
            set_m(1, 1, 0, rand_addr(), 2'b11, '0);
            @(negedge clk);
            check("contention_m0", 32'(m0_if.ready), 32'(((k / 8) % 2) == 0));
            check("contention_cs", 32'(sram_chipselect), 32'd1);
            cyc();
        end
        idle(); cyc(); cyc();

        // Reset lands in the cycle after an accepted m0 read.
        set_m(0, 1, 0, 12'h123, 2'b11, '0); cyc();
        apply_reset(1);
        repeat (4) cyc();
        idle(); cyc(); cyc();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            set_m(0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_addr(),
                  2'($urandom_range(0, 3)), 16'($urandom));
            set_m(1, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), rand_addr(),
                  2'($urandom_range(0, 3)), 16'($urandom));
            cyc();
        end
        idle(); cyc(); cyc(); cyc();

        // MAX_HOLD = 1: continuous writes from both must alternate.
        apply_reset(0);
        a0_if.valid = 1; a0_if.write = 1; a0_if.byteenable = 2'b11;
        a1_if.valid = 1; a1_if.write = 1; a1_if.byteenable = 2'b11;
        for (int k = 0; k < 20; k++) begin
            a0_if.address = rand_addr(); a0_if.writedata = 16'($urandom);
            a1_if.address = rand_addr(); a1_if.writedata = 16'($urandom);
            @(negedge clk);
            check("alt_m0_ready", 32'(a0_if.ready), 32'((k % 2) == 0));
            check("alt_m1_ready", 32'(a1_if.ready), 32'((k % 2) == 1));
            check("alt_cs",       32'(alt_chipselect), 32'd1);
            check("alt_wdata",    32'(alt_writedata),
                  32'(((k % 2) == 0) ? a0_if.writedata : a1_if.writedata));
            cyc();
        end
        a0_if.valid = 0; a1_if.valid = 0;
        cyc(); cyc();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
